fib_req_scheduler: RTL and testbench

FIB_REQ_SCHEDULER -- requirements
Module: fib_req_scheduler

---
 rtl/fib_req_scheduler.sv | 179 +++++++++++++++++
 tb/tb_fib_req_scheduler.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/fib_req_scheduler.sv
// fib_req_scheduler
//
// Two-requester Fibonacci term server. A round-robin arbiter accepts one
// request at a time. One shared adder then iterates F(0)=1, F(1)=1,
// F(n)=F(n-1)+F(n-2) until it reaches the requested index. The result is
// held on the response port until the consumer accepts it.
//
// Parameters
//   DATA_WIDTH : width of the result (results wrap modulo 2^DATA_WIDTH)
//   IDX_WIDTH  : width of the requested term index
//
// Ports
//   clk        : sole clock, rising edge
//   reset      : synchronous, active-high
//   req_valid  : [1:0] per-requester request valid
//   req_ready  : [1:0] per-requester accept (one-hot or zero)
//   req_idx0   : term index n from requester 0
//   req_idx1   : term index n from requester 1
//   resp_valid : response valid
//   resp_ready : response consumer accept
//   resp_id    : requester that owns the current response
//   resp_data  : F(n) modulo 2^DATA_WIDTH
//   resp_ovf   : F(n) did not fit in DATA_WIDTH bits
//   busy       : high whenever the scheduler is not idle
//
// States
//   ST_IDLE    | waiting for a request; arbiter drives req_ready
//   ST_COMPUTE | iterating the adder until count reaches the captured index
//   ST_RESP    | presenting the result until resp_ready
module fib_req_scheduler #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_WIDTH  = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [IDX_WIDTH-1:0]  req_idx0,
    input  logic [IDX_WIDTH-1:0]  req_idx1,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic                  resp_id,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_ovf,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] cur_q, cur_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [IDX_WIDTH-1:0]  count_q, count_d;
    logic [IDX_WIDTH-1:0]  idx_q, idx_d;
    logic                  id_q, id_d;
    logic                  ovf_q, ovf_d;
    logic                  last_q, last_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_id_q, resp_id_d;
    logic                  resp_ovf_q, resp_ovf_d;

    logic [1:0]            grant;
    logic                  grant_id;
    logic                  req_hs;
    logic [DATA_WIDTH:0]   sum_w;

    // Round-robin arbiter. last_q names the requester served most recently;
    // when both are valid the other one wins. Grants are suppressed while
    // reset is high so no handshake can coincide with a reset edge.
    always_comb begin
        grant = 2'b00;
        if (state_q == ST_IDLE && !reset) begin
            unique case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign grant_id = grant[1];
    assign req_hs   = |grant;

    // One extra bit catches the carry out of the shared adder.
    assign sum_w = {1'b0, cur_q} + {1'b0, prev_q};

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        prev_d      = prev_q;
        count_d     = count_q;
        idx_d       = idx_q;
        id_d        = id_q;
        ovf_d       = ovf_q;
        last_d      = last_q;
        resp_data_d = resp_data_q;
        resp_id_d   = resp_id_q;
        resp_ovf_d  = resp_ovf_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_hs) begin
                    idx_d   = grant_id ? req_idx1 : req_idx0;
                    id_d    = grant_id;
                    last_d  = grant_id;
                    cur_d   = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
                    prev_d  = '0;
                    count_d = '0;
                    ovf_d   = 1'b0;
                    state_d = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                if (count_q == idx_q) begin
                    resp_data_d = cur_q;
                    resp_id_d   = id_q;
                    resp_ovf_d  = ovf_q;
                    state_d     = ST_RESP;
                end else begin
                    cur_d   = sum_w[DATA_WIDTH-1:0];
                    prev_d  = cur_q;
                    count_d = count_q + 1'b1;
                    ovf_d   = ovf_q | sum_w[DATA_WIDTH];
                end
            end
            ST_RESP: begin
                // Returning to IDLE costs one cycle, so a new request can
                // never be accepted on the response handshake cycle.
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cur_q       <= '0;
            prev_q      <= '0;
            count_q     <= '0;
            idx_q       <= '0;
            id_q        <= 1'b0;
            ovf_q       <= 1'b0;
            last_q      <= 1'b1;
            resp_data_q <= '0;
            resp_id_q   <= 1'b0;
            resp_ovf_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            prev_q      <= prev_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            id_q        <= id_d;
            ovf_q       <= ovf_d;
            last_q      <= last_d;
            resp_data_q <= resp_data_d;
            resp_id_q   <= resp_id_d;
            resp_ovf_q  <= resp_ovf_d;
        end
    end

    assign req_ready  = grant;
    assign resp_valid = (state_q == ST_RESP);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;
    assign resp_ovf   = resp_ovf_q;
    assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fib_req_scheduler.sv
module tb_fib_req_scheduler;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [5:0]  req_idx0;
    logic [5:0]  req_idx1;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_id;
    logic [31:0] resp_data;
    logic        resp_ovf;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fib_req_scheduler #(.DATA_WIDTH(32), .IDX_WIDTH(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_idx0   (req_idx0),
        .req_idx1   (req_idx1),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ovf   (resp_ovf),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Waits for resp_valid; lat counts cycles since the handshake cycle.
    task automatic wait_resp(inout int lat);
        while (!resp_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    // Single-requester transaction with resp_ready held high. The index
    // input is scrambled right after the handshake to show it is ignored.
    task automatic do_req(input string tag, input int id, input int n,
                          input logic [31:0] exp_d, input logic exp_o);
        int lat;
        if (id == 0) req_idx0 = 6'(n); else req_idx1 = 6'(n);
        req_valid = (id == 0) ? 2'b01 : 2'b10;
        #1;
        chk({tag, "_ready"}, 64'(req_ready), 64'(req_valid));
        tick();
        req_valid = 2'b00;
        if (id == 0) req_idx0 = ~6'(n); else req_idx1 = ~6'(n);
        lat = 1;
        chk({tag, "_busy"}, 64'(busy), 64'd1);
        wait_resp(lat);
        chk({tag, "_latency"}, 64'(lat), 64'(n + 2));
        chk({tag, "_id"}, 64'(resp_id), 64'(id));
        chk({tag, "_data"}, 64'(resp_data), 64'(exp_d));
        chk({tag, "_ovf"}, 64'(resp_ovf), 64'(exp_o));
        tick();
        chk({tag, "_done"}, 64'(resp_valid), 64'd0);
        chk({tag, "_hold"}, 64'(resp_data), 64'(exp_d));
    endtask

    initial begin
        int lat;
        logic seen;

        reset      = 1'b1;
        req_valid  = 2'b11;
        req_idx0   = 6'd0;
        req_idx1   = 6'd0;
        resp_ready = 1'b1;
        tick();
        tick();
        chk("rst_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_ovf", 64'(resp_ovf), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        req_valid = 2'b00;
        reset     = 1'b0;
        tick();
        chk("idle_no_valid_ready", 64'(req_ready), 64'd0);

        // Single request, n=5 -> 8 after 7 cycles.
        do_req("single_n5", 0, 5, 32'd8, 1'b0);
        do_req("single_n0_r1", 1, 0, 32'd1, 1'b0);

        // Overflow boundary.
        do_req("n46", 1, 46, 32'd2971215073, 1'b0);
        do_req("n47", 0, 47, 32'd512559680, 1'b1);
        do_req("n46_clr", 0, 46, 32'd2971215073, 1'b0);

        // Backpressure with n=3; both requesters pound on req_valid meanwhile.
        resp_ready = 1'b0;
        req_idx0   = 6'd3;
        req_valid  = 2'b01;
        tick();
        req_valid = 2'b11;
        lat = 1;
        wait_resp(lat);
        chk("bp_latency", 64'(lat), 64'd5);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(resp_valid), 64'd1);
            chk("bp_data", 64'(resp_data), 64'd3);
            chk("bp_ready", 64'(req_ready), 64'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(req_ready), 64'd0);
        req_valid = 2'b00;
        tick();
        chk("bp_single_resp", 64'(resp_valid), 64'd0);
        chk("bp_idle", 64'(busy), 64'd0);

        // Contention right after reset.
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        req_idx0  = 6'd10;
        req_idx1  = 6'd0;
        req_valid = 2'b11;
        #1;
        chk("ct_grant0", 64'(req_ready), 64'd1);
        tick();
        lat = 1;
        wait_resp(lat);
        chk("ct_r1_lat", 64'(lat), 64'd12);
        chk("ct_r1_id", 64'(resp_id), 64'd0);
        chk("ct_r1_data", 64'(resp_data), 64'd89);
        tick();
        chk("ct_grant1", 64'(req_ready), 64'd2);
        tick();
        lat = 1;
        wait_resp(lat);
        chk("ct_r2_lat", 64'(lat), 64'd2);
        chk("ct_r2_id", 64'(resp_id), 64'd1);
        chk("ct_r2_data", 64'(resp_data), 64'd1);
        tick();
        chk("ct_grant0_again", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        lat = 1;
        wait_resp(lat);
        chk("ct_r3_id", 64'(resp_id), 64'd0);
        chk("ct_r3_data", 64'(resp_data), 64'd89);
        tick();

        // Reset mid-COMPUTE with n=20.
        req_idx1  = 6'd20;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        tick();
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_ready", 64'(req_ready), 64'd0);
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (resp_valid) seen = 1'b1;
        end
        chk("mid_rst_no_resp", 64'(seen), 64'd0);
        do_req("after_rst_n2", 0, 2, 32'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
